// File: rtl/cpu_muldiv_pkg.sv
// cpu_muldiv_pkg: op/state encodings and funct3 decode helpers for cpu_muldiv
package cpu_muldiv_pkg;
  typedef enum logic [2:0] {
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } op_t;
  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;
  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction
  function automatic logic is_signed_a(input logic [2:0] op);
    return op[2] ? ~op[0] : (op[1:0] != 2'b11);
  endfunction
  function automatic logic is_signed_b(input logic [2:0] op);
    return op[2] ? ~op[0] : ~op[1];
  endfunction
endpackage

// File: rtl/cpu_muldiv_negate.sv
// cpu_muldiv_negate: conditional two's-complement negation of a W-bit value
module cpu_muldiv_negate #(
  parameter int W = 32
) (
  input  logic         en,
  input  logic [W-1:0] a,
  output logic [W-1:0] y
);
  assign y = en ? -a : a;
endmodule

// File: rtl/cpu_muldiv.sv
// cpu_muldiv: iterative RV32M mul/div; define CPU_MULDIV_FAST_SPECIAL_EN to let div-by-zero/overflow skip CALC
module cpu_muldiv
  import cpu_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  state_t state;
  logic [2:0] op_q;
  logic sa, sb, special_q;
  logic [XLEN-1:0] ma, mb, rem, spec_q;
  logic [2*XLEN-1:0] acc;
  logic [CW-1:0] cnt;
  logic in_sa, in_sb, dbz, ovf, special, ge, fix_en;
  logic [XLEN-1:0] abs_a, abs_b, spec_res, diff, quo_nxt, rem_nxt, res_calc;
  logic [XLEN:0] mul_sum, shifted;
  logic [2*XLEN-1:0] mul_nxt, fix_in, fixed;
  always_comb begin
    in_sa = is_signed_a(op) & src_a[XLEN-1];
    in_sb = is_signed_b(op) & src_b[XLEN-1];
    dbz = is_div(op) & (src_b == '0);
    ovf = is_div(op) & ~op[0] & (src_a == MIN_NEG) & (&src_b);
    special = dbz | ovf;
    spec_res = dbz ? (op[1] ? src_a : '1) : (op[1] ? '0 : MIN_NEG);
    mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, ma} : '0);
    mul_nxt = {mul_sum, acc[XLEN-1:1]};
    shifted = {rem, acc[XLEN-1]};
    ge = shifted >= {1'b0, mb};
    diff = shifted[XLEN-1:0] - mb;
    rem_nxt = ge ? diff : shifted[XLEN-1:0];
    quo_nxt = {acc[XLEN-2:0], ge};
    fix_in = is_div(op_q) ? {{XLEN{1'b0}}, op_q[1] ? rem_nxt : quo_nxt} : mul_nxt;
    // remainder follows the dividend's sign; quotient and product use sa^sb
    fix_en = (is_div(op_q) & op_q[1]) ? sa : sa ^ sb;
    res_calc = special_q ? spec_q
             : (op_q[2] | (op_q[1:0] == 2'b00)) ? fixed[XLEN-1:0] : fixed[2*XLEN-1:XLEN];
  end
  cpu_muldiv_negate #(.W(XLEN)) u_abs_a (.en(in_sa), .a(src_a), .y(abs_a));
  cpu_muldiv_negate #(.W(XLEN)) u_abs_b (.en(in_sb), .a(src_b), .y(abs_b));
  cpu_muldiv_negate #(.W(2*XLEN)) u_fix (.en(fix_en), .a(fix_in), .y(fixed));
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      done <= 1'b0;
      result <= '0;
      op_q <= '0;
      sa <= 1'b0;
      sb <= 1'b0;
      special_q <= 1'b0;
      spec_q <= '0;
      ma <= '0;
      mb <= '0;
      rem <= '0;
      acc <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op_q <= op;
          sa <= in_sa;
          sb <= in_sb;
          ma <= abs_a;
          mb <= abs_b;
          acc <= {{XLEN{1'b0}}, is_div(op) ? abs_a : abs_b};
          rem <= '0;
          cnt <= CW'(XLEN-1);
          special_q <= special;
          spec_q <= spec_res;
`ifdef CPU_MULDIV_FAST_SPECIAL_EN
          if (special) begin
            state <= FINISH;
            done <= 1'b1;
            result <= spec_res;
          end else
`endif
          state <= CALC;
        end
        CALC: begin
          acc <= is_div(op_q) ? {{XLEN{1'b0}}, quo_nxt} : mul_nxt;
          rem <= rem_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            state <= FINISH;
            done <= 1'b1;
            result <= res_calc;
          end
        end
        FINISH: begin
          state <= IDLE;
          done <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_muldiv.sv
// tb_cpu_muldiv: scoreboard bench for cpu_muldiv with directed RV32M vectors
module tb_cpu_muldiv;
  import cpu_muldiv_pkg::*;
  typedef struct {
    logic [31:0] exp;
    int          due;
    int          id;
  } item_t;
  logic clk = 0, rst = 1, start = 0;
  logic [2:0] op = 0;
  logic [31:0] src_a = 0, src_b = 0;
  logic busy, done;
  logic [31:0] result;
  int cyc = 0, tests = 0, fails = 0, nid = 0;
  item_t sb_q[$];
`ifdef CPU_MULDIV_FAST_SPECIAL_EN
  localparam int SP = 1;
`else
  localparam int SP = 33;
`endif
  cpu_muldiv dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .busy(busy), .done(done), .result(result)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endfunction
  always @(negedge clk) if (done) begin
    if (sb_q.size() == 0) chk("spurious_done", {31'b0, done}, 32'h0);
    else begin
      item_t e;
      e = sb_q.pop_front();
      chk($sformatf("result_%0d", e.id), result, e.exp);
      chk($sformatf("done_cycle_%0d", e.id), 32'(cyc), 32'(e.due));
    end
  end
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] e, input int lat);
    start = 1; op = o; src_a = a; src_b = b;
    sb_q.push_back('{e, cyc + lat, nid});
    nid++;
    @(negedge clk);
    start = 0; op = 3'($urandom_range(0, 7)); src_a = $urandom; src_b = $urandom;
  endtask
  task automatic wait_idle(input int exp_busy, input string nm);
    int n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk(nm, 32'(n), 32'(exp_busy));
  endtask
  task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] e, input int lat);
    issue(o, a, b, e, lat);
    wait_idle(lat, $sformatf("busy_len_%0d", nid - 1));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'b0, busy}, 32'h0);
    chk("reset_done", {31'b0, done}, 32'h0);
    chk("reset_result", result, 32'h0);
    rst = 0;
    @(negedge clk);
    run(OP_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    run(OP_MULH, 32'h80000000, 32'h80000000, 32'h40000000, 33);
    run(OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
    run(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run(OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
    run(OP_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
    run(OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
    run(OP_REMU, 32'd100, 32'd7, 32'd2, 33);
    run(OP_DIV, 32'hFFFFFFEC, 32'hFFFFFFFD, 32'd6, 33);
    run(OP_REM, 32'hFFFFFFEC, 32'hFFFFFFFD, 32'hFFFFFFFE, 33);
    run(OP_DIV, 32'd20, 32'hFFFFFFFD, 32'hFFFFFFFA, 33);
    run(OP_REM, 32'd20, 32'hFFFFFFFD, 32'd2, 33);
    run(OP_DIV, 32'd5, 32'd0, 32'hFFFFFFFF, SP);
    run(OP_REM, 32'd5, 32'd0, 32'd5, SP);
    run(OP_DIVU, 32'h12345678, 32'd0, 32'hFFFFFFFF, SP);
    run(OP_REMU, 32'h12345678, 32'd0, 32'h12345678, SP);
    run(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, SP);
    run(OP_REM, 32'h80000000, 32'hFFFFFFFF, 32'h0, SP);
    run(OP_DIVU, 32'h80000000, 32'hFFFFFFFF, 32'h0, 33);
    // second start mid-operation must be dropped; next accept lands on cycle 34
    issue(OP_MUL, 32'd3, 32'd5, 32'd15, 33);
    repeat (9) @(negedge clk);
    start = 1; op = OP_MULHU; src_a = 32'hFFFFFFFF; src_b = 32'hFFFFFFFF;
    @(negedge clk);
    start = 0;
    wait_idle(23, "busy_after_ignored_start");
    run(OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
    issue(OP_DIV, 32'd100, 32'd7, 32'd14, 33);
    repeat (14) @(negedge clk);
    rst = 1;
    #1;
    chk("midop_reset_busy", {31'b0, busy}, 32'h0);
    chk("midop_reset_done", {31'b0, done}, 32'h0);
    chk("midop_reset_result", result, 32'h0);
    sb_q.delete();
    @(negedge clk);
    rst = 0;
    repeat (40) @(negedge clk);
    run(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run(OP_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
